// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - RV64 ALU-op decoder with a 2-entry decoded-op issue buffer
module alu_issue_ctrl #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [63:0] rs1_data,
    input  logic [63:0] rs2_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  ALUOp,
    output logic [63:0] a,
    output logic [63:0] b,
    output logic [7:0]  illegal_cnt
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b1000;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [63:0] imm_i;
    logic [63:0] imm_s;
    logic [63:0] shamt;

    logic        dec_legal;
    logic [3:0]  dec_op;
    logic [63:0] dec_b;

    // Head entry lives in slot 0; slot 1 only holds the second-oldest entry.
    logic [1:0]  occ;
    logic [3:0]  op0, op1;
    logic [63:0] a0, a1, b0, b1;

    logic accept;
    logic push;
    logic pop;
    logic unused_rs1_field;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = {{52{instr[31]}}, instr[31:20]};
    assign imm_s  = {{52{instr[31]}}, instr[31:25], instr[11:7]};
    assign shamt  = {58'd0, instr[25:20]};

    // Register indices are resolved upstream; only the operand data matters here.
    assign unused_rs1_field = ^instr[19:15];

    // Classify the instruction and select the ALU op and operand B.
    always_comb begin
        dec_legal = 1'b0;
        dec_op    = OP_AND;
        dec_b     = rs2_data;
        case (opcode)
            7'b0110011: begin
                if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
                    dec_legal = 1'b1;
                    dec_op    = OP_ADD;
                end else if (funct3 == 3'b000 && funct7 == 7'b0100000) begin
                    dec_legal = 1'b1;
                    dec_op    = OP_SUB;
                end else if (funct3 == 3'b111 && funct7 == 7'b0000000) begin
                    dec_legal = 1'b1;
                    dec_op    = OP_AND;
                end else if (funct3 == 3'b110 && funct7 == 7'b0000000) begin
                    dec_legal = 1'b1;
                    dec_op    = OP_OR;
                end
            end
            7'b0010011: begin
                if (funct3 == 3'b000) begin
                    dec_legal = 1'b1;
                    dec_op    = OP_ADD;
                    dec_b     = imm_i;
                end else if (funct3 == 3'b001 && instr[31:26] == 6'd0) begin
                    dec_legal = 1'b1;
                    dec_op    = OP_SLL;
                    dec_b     = shamt;
                end
            end
            7'b0000011: begin
                if (funct3 == 3'b011) begin
                    dec_legal = 1'b1;
                    dec_op    = OP_ADD;
                    dec_b     = imm_i;
                end
            end
            7'b0100011: begin
                if (funct3 == 3'b011) begin
                    dec_legal = 1'b1;
                    dec_op    = OP_ADD;
                    dec_b     = imm_s;
                end
            end
            7'b1100011: begin
                if (funct3 == 3'b000) begin
                    dec_legal = 1'b1;
                    dec_op    = OP_SUB;
                end
            end
            default: ;
        endcase
    end

    assign in_ready  = int'(occ) < DEPTH;
    assign out_valid = (occ != 2'd0);
    assign accept    = in_valid && in_ready;
    assign push      = accept && dec_legal;
    assign pop       = out_valid && out_ready;

    // Outputs come straight from slot 0, forced to zero while the buffer is empty.
    assign ALUOp = out_valid ? op0 : 4'd0;
    assign a     = out_valid ? a0  : 64'd0;
    assign b     = out_valid ? b0  : 64'd0;

    // Shift-style FIFO: a pop moves slot 1 into slot 0, a push fills the lowest free slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ <= 2'd0;
            op0 <= 4'd0;
            a0  <= 64'd0;
            b0  <= 64'd0;
            op1 <= 4'd0;
            a1  <= 64'd0;
            b1  <= 64'd0;
        end else if (flush) begin
            occ <= 2'd0;
        end else if (push && pop) begin
            // Only reachable at occupancy 1, since a full buffer refuses pushes.
            op0 <= dec_op;
            a0  <= rs1_data;
            b0  <= dec_b;
        end else if (pop) begin
            op0 <= op1;
            a0  <= a1;
            b0  <= b1;
            occ <= occ - 2'd1;
        end else if (push) begin
            if (occ == 2'd0) begin
                op0 <= dec_op;
                a0  <= rs1_data;
                b0  <= dec_b;
            end else begin
                op1 <= dec_op;
                a1  <= rs1_data;
                b1  <= dec_b;
            end
            occ <= occ + 2'd1;
        end
    end

    // Count dropped undecodable instructions; flush does not cancel the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            illegal_cnt <= 8'd0;
        end else if (accept && !dec_legal && illegal_cnt != 8'hFF) begin
            illegal_cnt <= illegal_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed-vector self-checking bench for alu_issue_ctrl
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  ALUOp;
    logic [63:0] a;
    logic [63:0] b;
    logic [7:0]  illegal_cnt;

    int n_vec = 0;
    int n_bad = 0;

    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_SUB   = 32'h402081B3;
    localparam logic [31:0] I_AND   = 32'h0020F1B3;
    localparam logic [31:0] I_OR    = 32'h0020E1B3;
    localparam logic [31:0] I_SLLI  = 32'h00309293;
    localparam logic [31:0] I_SLLIX = 32'h04309293;
    localparam logic [31:0] I_ADDIM = 32'hFFF08093;
    localparam logic [31:0] I_SDM8  = 32'hFE20BC23;
    localparam logic [31:0] I_LD8   = 32'h00813083;
    localparam logic [31:0] I_BEQ   = 32'h00208063;
    localparam logic [31:0] I_BAD   = 32'hFFFFFFFF;

    alu_issue_ctrl #(.DEPTH(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ALUOp       (ALUOp),
        .a           (a),
        .b           (b),
        .illegal_cnt (illegal_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] i, input logic [63:0] r1, input logic [63:0] r2);
        in_valid = v;
        instr    = i;
        rs1_data = r1;
        rs2_data = r2;
    endtask

    task automatic chk_head(input string tag, input logic [3:0] op, input logic [63:0] ea, input logic [63:0] eb);
        chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        chk({tag, "_op"}, {60'd0, ALUOp}, {60'd0, op});
        chk({tag, "_a"}, a, ea);
        chk({tag, "_b"}, b, eb);
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_op"}, {60'd0, ALUOp}, 64'd0);
        chk({tag, "_a"}, a, 64'd0);
        chk({tag, "_b"}, b, 64'd0);
        chk({tag, "_rdy"}, {63'd0, in_ready}, 64'd1);
    endtask

    // One legal instruction pushed into an empty buffer, seen the next cycle, then drained.
    task automatic single(input string tag, input logic [31:0] i, input logic [63:0] r1,
                          input logic [63:0] r2, input logic [3:0] op, input logic [63:0] eb);
        out_ready = 1'b1;
        drive(1'b1, i, r1, r2);
        tick();
        drive(1'b0, 32'd0, 64'd0, 64'd0);
        chk_head(tag, op, r1, eb);
        tick();
        chk({tag, "_drained"}, {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        logic seen_valid;
        reset     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'd0, 64'd0, 64'd0);
        #12;
        chk_empty("reset");
        chk("reset_cnt", {56'd0, illegal_cnt}, 64'd0);
        reset = 1'b1;

        // Single-entry decode and latency across the supported encodings.
        single("add",   I_ADD,   64'd5,   64'd7,  4'b0010, 64'd7);
        chk_empty("after_add");
        single("slli",  I_SLLI,  64'd1,   64'd0,  4'b1000, 64'd3);
        single("addim", I_ADDIM, 64'd100, 64'd0,  4'b0010, 64'hFFFF_FFFF_FFFF_FFFF);
        single("sdm8",  I_SDM8,  64'h1000, 64'd9, 4'b0010, 64'hFFFF_FFFF_FFFF_FFF8);
        single("ld8",   I_LD8,   64'h2000, 64'd0, 4'b0010, 64'd8);
        single("beq",   I_BEQ,   64'd9,   64'd4,  4'b0110, 64'd4);
        single("or",    I_OR,    64'hA0,  64'h0F, 4'b0001, 64'h0F);

        // Fill to two entries, hold while stalled, then drain in order.
        out_ready = 1'b0;
        drive(1'b1, I_SUB, 64'd10, 64'd3);
        tick();
        drive(1'b1, I_AND, 64'hF0, 64'h3C);
        tick();
        chk("full_rdy", {63'd0, in_ready}, 64'd0);
        chk_head("full_head", 4'b0110, 64'd10, 64'd3);
        drive(1'b1, I_BAD, 64'd1, 64'd1);
        tick();
        chk_head("stall_hold", 4'b0110, 64'd10, 64'd3);
        chk("stall_nocnt", {56'd0, illegal_cnt}, 64'd0);
        drive(1'b0, 32'd0, 64'd0, 64'd0);
        out_ready = 1'b1;
        tick();
        chk_head("drain2", 4'b0000, 64'hF0, 64'h3C);
        chk("drain_rdy", {63'd0, in_ready}, 64'd1);
        tick();
        chk_empty("drained");

        // Simultaneous push and pop at occupancy 1.
        out_ready = 1'b0;
        drive(1'b1, I_OR, 64'd1, 64'd2);
        tick();
        out_ready = 1'b1;
        drive(1'b1, I_ADD, 64'd20, 64'd30);
        tick();
        drive(1'b0, 32'd0, 64'd0, 64'd0);
        chk_head("pushpop", 4'b0010, 64'd20, 64'd30);
        chk("pushpop_rdy", {63'd0, in_ready}, 64'd1);
        tick();
        chk_empty("pushpop_end");

        // Flush with a full buffer and a bundle offered.
        out_ready = 1'b0;
        drive(1'b1, I_ADD, 64'd1, 64'd1);
        tick();
        drive(1'b1, I_ADD, 64'd2, 64'd2);
        tick();
        drive(1'b1, I_ADD, 64'd3, 64'd3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'd0, 64'd0, 64'd0);
        chk_empty("flush_full");
        tick();
        chk("flush_full_stay", {63'd0, out_valid}, 64'd0);

        // Flush at occupancy 1 discards the same-cycle legal push and pop.
        drive(1'b1, I_ADD, 64'd4, 64'd4);
        tick();
        out_ready = 1'b1;
        drive(1'b1, I_ADD, 64'd5, 64'd5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'd0, 64'd0, 64'd0);
        chk_empty("flush_one");

        // Illegal encodings: slli with instr[26] set, illegal under flush, then saturation.
        drive(1'b1, I_SLLIX, 64'd1, 64'd1);
        tick();
        drive(1'b0, 32'd0, 64'd0, 64'd0);
        chk("ill_slli_cnt", {56'd0, illegal_cnt}, 64'd1);
        chk("ill_slli_valid", {63'd0, out_valid}, 64'd0);
        drive(1'b1, I_BAD, 64'd1, 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'd0, 64'd0, 64'd0);
        chk("ill_flush_cnt", {56'd0, illegal_cnt}, 64'd2);
        seen_valid = 1'b0;
        drive(1'b1, I_BAD, 64'd1, 64'd1);
        for (int i = 0; i < 300; i++) begin
            tick();
            if (out_valid) seen_valid = 1'b1;
        end
        drive(1'b0, 32'd0, 64'd0, 64'd0);
        chk("ill_sat_cnt", {56'd0, illegal_cnt}, 64'd255);
        chk("ill_never_valid", {63'd0, seen_valid}, 64'd0);

        // Asynchronous reset between edges with one entry buffered.
        out_ready = 1'b0;
        drive(1'b1, I_ADD, 64'd5, 64'd7);
        tick();
        drive(1'b0, 32'd0, 64'd0, 64'd0);
        chk_head("pre_rst", 4'b0010, 64'd5, 64'd7);
        #2;
        reset = 1'b0;
        #1;
        chk_empty("async_rst");
        chk("async_rst_cnt", {56'd0, illegal_cnt}, 64'd0);
        #1;
        reset = 1'b1;
        tick();
        chk_empty("post_rst");
        out_ready = 1'b1;
        single("post_rst_add", I_ADD, 64'd11, 64'd22, 4'b0010, 64'd22);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
